// File: rtl/gpu_raster_engine_if.sv
// Raster command opcodes and the CPU/GPU command + framebuffer bundle.
// The engine sits on the slave side; the command issuer is the master.
package common;
    typedef enum logic [2:0] {
        CMD_FILL  = 3'd0,
        CMD_POINT = 3'd1,
        CMD_LINE  = 3'd2,
        CMD_RECT  = 3'd3
    } raster_command_t;
endpackage

interface gpu_raster_if #(
    parameter int ADDR_W = 16
);
    import common::*;

    raster_command_t   gpu_command;
    logic [7:0]        gpu_x0;
    logic [7:0]        gpu_y0;
    logic [7:0]        gpu_x1;
    logic [7:0]        gpu_y1;
    logic [2:0]        gpu_colour;
    logic              gpu_execute_request;
    logic              gpu_busy;
    logic [ADDR_W-1:0] fb_addr;
    logic [2:0]        fb_data;
    logic              fb_write;

    modport master (
        output gpu_command,
        output gpu_x0, gpu_y0,
        output gpu_x1, gpu_y1,
        output gpu_colour,
        output gpu_execute_request,
        input  gpu_busy,
        input  fb_addr, fb_data,
        input  fb_write
    );

    modport slave (
        input  gpu_command,
        input  gpu_x0, gpu_y0,
        input  gpu_x1, gpu_y1,
        input  gpu_colour,
        input  gpu_execute_request,
        output gpu_busy,
        output fb_addr, fb_data,
        output fb_write
    );
endinterface

// File: rtl/gpu_raster_engine.sv
// Raster engine: FILL/POINT/LINE/RECT, one candidate pixel per clock,
// driving a registered single-port framebuffer write port.
module gpu_raster_engine
    import common::*;
#(
    parameter int SCREEN_W = 214,
    parameter int SCREEN_H = 160,
    parameter int ADDR_W   = 16
) (
    input  logic       clk,
    input  logic       rst_sync,
    gpu_raster_if.slave gpu_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRAW
    } state_e;

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);

    state_e            state_q, state_d;
    raster_command_t   cmd_q, cmd_d;
    logic [7:0]        x0_q, x0_d, y0_q, y0_d;
    logic [7:0]        x1_q, x1_d, y1_q, y1_d;
    logic [2:0]        col_q, col_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [9:0]        xmin_q, xmin_d, xmax_q, xmax_d;
    logic [9:0]        ymax_q, ymax_d;
    logic signed [10:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [10:0] err_q, err_d;
    logic              sxn_q, sxn_d, syn_q, syn_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [2:0]        fb_data_q, fb_data_d;
    logic              fb_write_q, fb_write_d;

    logic [9:0]         nx, ny;
    logic [ADDR_W-1:0]  nbase;
    logic signed [10:0] nerr, ddx, ddy, adx, ady;
    logic signed [11:0] e2, dxw, dyw;
    logic               last;

    // Constant-coefficient row base as a shift-add chain.
    function automatic logic [ADDR_W-1:0] row_base(
        input logic [9:0] y
    );
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++) begin
            if (SCREEN_W[i]) begin
                acc = acc + (ADDR_W'(y) << i);
            end
        end
        return acc;
    endfunction

    function automatic logic on_screen(
        input logic [9:0] x,
        input logic [9:0] y
    );
        return (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    endfunction

    assign gpu_if.gpu_busy = (state_q != S_IDLE);
    assign gpu_if.fb_addr  = fb_addr_q;
    assign gpu_if.fb_data  = fb_data_q;
    assign gpu_if.fb_write = fb_write_q;

    assign ddx = $signed({3'b000, x1_q}) - $signed({3'b000, x0_q});
    assign ddy = $signed({3'b000, y1_q}) - $signed({3'b000, y0_q});
    assign adx = ddx[10] ? -ddx : ddx;
    assign ady = ddy[10] ? -ddy : ddy;
    assign e2  = {err_q, 1'b0};
    assign dxw = {dx_q[10], dx_q};
    assign dyw = {dy_q[10], dy_q};

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        col_d      = col_q;
        x_d        = x_q;
        y_d        = y_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymax_d     = ymax_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        err_d      = err_q;
        sxn_d      = sxn_q;
        syn_d      = syn_q;
        base_d     = base_q;
        fb_addr_d  = fb_addr_q;
        fb_data_d  = fb_data_q;
        fb_write_d = 1'b0;
        nx         = x_q;
        ny         = y_q;
        nbase      = base_q;
        nerr       = err_q;
        last       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (gpu_if.gpu_execute_request) begin
                    cmd_d   = gpu_if.gpu_command;
                    x0_d    = gpu_if.gpu_x0;
                    y0_d    = gpu_if.gpu_y0;
                    x1_d    = gpu_if.gpu_x1;
                    y1_d    = gpu_if.gpu_y1;
                    col_d   = gpu_if.gpu_colour;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                state_d = S_DRAW;
                dx_d    = adx;
                dy_d    = ady;
                err_d   = adx - ady;
                sxn_d   = ddx[10];
                syn_d   = ddy[10];
                unique case (cmd_q)
                    CMD_FILL: begin
                        xmin_d = '0;
                        xmax_d = 10'(SCREEN_W - 1);
                        ymax_d = 10'(SCREEN_H - 1);
                        nx     = '0;
                        ny     = '0;
                    end
                    CMD_RECT: begin
                        xmin_d = {2'b00, (x0_q < x1_q) ? x0_q : x1_q};
                        xmax_d = {2'b00, (x0_q < x1_q) ? x1_q : x0_q};
                        ymax_d = {2'b00, (y0_q < y1_q) ? y1_q : y0_q};
                        nx     = xmin_d;
                        ny     = {2'b00, (y0_q < y1_q) ? y0_q : y1_q};
                    end
                    CMD_POINT, CMD_LINE: begin
                        nx = {2'b00, x0_q};
                        ny = {2'b00, y0_q};
                    end
                    default: state_d = S_IDLE;
                endcase
                nbase = row_base(ny);
                if (state_d == S_DRAW) begin
                    x_d        = nx;
                    y_d        = ny;
                    base_d     = nbase;
                    fb_write_d = on_screen(nx, ny);
                    fb_addr_d  = nbase + ADDR_W'(nx);
                    fb_data_d  = col_q;
                end
            end

            S_DRAW: begin
                unique case (cmd_q)
                    CMD_POINT: last = 1'b1;
                    CMD_LINE: begin
                        last = (x_q == {2'b00, x1_q}) &&
                               (y_q == {2'b00, y1_q});
                    end
                    default: begin
                        last = (x_q == xmax_q) && (y_q == ymax_q);
                    end
                endcase
                if (last) begin
                    state_d = S_IDLE;
                end else begin
                    if (cmd_q == CMD_LINE) begin
                        // Both steps may fire together on a diagonal move.
                        if (e2 > -dyw) begin
                            nerr = nerr - dy_q;
                            nx   = sxn_q ? x_q - 10'd1 : x_q + 10'd1;
                        end
                        if (e2 < dxw) begin
                            nerr  = nerr + dx_q;
                            ny    = syn_q ? y_q - 10'd1 : y_q + 10'd1;
                            nbase = syn_q ? base_q - ROW_STEP
                                          : base_q + ROW_STEP;
                        end
                    end else if (x_q == xmax_q) begin
                        nx    = xmin_q;
                        ny    = y_q + 10'd1;
                        nbase = base_q + ROW_STEP;
                    end else begin
                        nx = x_q + 10'd1;
                    end
                    x_d        = nx;
                    y_d        = ny;
                    base_d     = nbase;
                    err_d      = nerr;
                    fb_write_d = on_screen(nx, ny);
                    fb_addr_d  = nbase + ADDR_W'(nx);
                    fb_data_d  = col_q;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q    <= S_IDLE;
            fb_write_q <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            fb_write_q <= fb_write_d;
            fb_addr_q  <= fb_addr_d;
            fb_data_q  <= fb_data_d;
        end
    end

    // Datapath holds only meaningful values outside IDLE; no reset needed.
    always_ff @(posedge clk) begin
        cmd_q  <= cmd_d;
        x0_q   <= x0_d;
        y0_q   <= y0_d;
        x1_q   <= x1_d;
        y1_q   <= y1_d;
        col_q  <= col_d;
        x_q    <= x_d;
        y_q    <= y_d;
        xmin_q <= xmin_d;
        xmax_q <= xmax_d;
        ymax_q <= ymax_d;
        dx_q   <= dx_d;
        dy_q   <= dy_d;
        err_q  <= err_d;
        sxn_q  <= sxn_d;
        syn_q  <= syn_d;
        base_q <= base_d;
    end

endmodule

// File: tb/tb_gpu_raster_engine.sv
// Directed bench for gpu_raster_engine: command timing, write order,
// clipping, held requests, mid-command reset and unknown opcodes.
module tb_gpu_raster_engine;
    import common::*;

    localparam int W = 214;
    localparam int H = 160;

    logic clk = 1'b0;
    logic rst_sync = 1'b1;

    gpu_raster_if #(.ADDR_W(16)) gif ();

    gpu_raster_engine #(
        .SCREEN_W(W),
        .SCREEN_H(H),
        .ADDR_W(16)
    ) dut (
        .clk     (clk),
        .rst_sync(rst_sync),
        .gpu_if  (gif)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int wa[$];
    int wd[$];
    int busy_n;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input raster_command_t c,
                         input int x0, input int y0,
                         input int x1, input int y1,
                         input int col, input bit hold);
        @(negedge clk);
        gif.gpu_command = c;
        gif.gpu_x0 = 8'(x0);
        gif.gpu_y0 = 8'(y0);
        gif.gpu_x1 = 8'(x1);
        gif.gpu_y1 = 8'(y1);
        gif.gpu_colour = 3'(col);
        gif.gpu_execute_request = 1'b1;
        @(negedge clk);
        if (!hold) begin
            gif.gpu_execute_request = 1'b0;
            gif.gpu_command = CMD_FILL;
            gif.gpu_x0 = 8'hA5;
            gif.gpu_y0 = 8'h5A;
            gif.gpu_x1 = 8'h33;
            gif.gpu_y1 = 8'hCC;
            gif.gpu_colour = 3'd7;
        end
    endtask

    task automatic capture(input int limit);
        wa.delete();
        wd.delete();
        busy_n = 0;
        while (gif.gpu_busy && busy_n < limit) begin
            if (gif.fb_write) begin
                wa.push_back(int'(gif.fb_addr));
                wd.push_back(int'(gif.fb_data));
            end
            busy_n++;
            @(negedge clk);
        end
        chk("idle_no_write", int'(gif.fb_write), 0);
    endtask

    task automatic chk_seq(input string tag, input int e[$]);
        chk({tag, "_count"}, wa.size(), e.size());
        for (int i = 0; i < e.size() && i < wa.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wa[i], e[i]);
        end
    endtask

    task automatic chk_data(input string tag, input int col);
        int bad;
        bad = 0;
        foreach (wd[i]) if (wd[i] != col) bad++;
        chk(tag, bad, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        int bad;
        gif.gpu_command = CMD_FILL;
        gif.gpu_x0 = '0;
        gif.gpu_y0 = '0;
        gif.gpu_x1 = '0;
        gif.gpu_y1 = '0;
        gif.gpu_colour = '0;
        gif.gpu_execute_request = 1'b0;
        repeat (3) @(negedge clk);
        rst_sync = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(gif.gpu_busy), 0);
        chk("rst_wr", int'(gif.fb_write), 0);
        chk("rst_addr", int'(gif.fb_addr), 0);
        chk("rst_data", int'(gif.fb_data), 0);

        drive(CMD_POINT, 100, 100, 0, 0, 6, 1'b0);
        capture(10);
        chk("point_busy", busy_n, 2);
        e = '{21500};
        chk_seq("point", e);
        chk_data("point_data", 6);

        e = '{4290, 4291, 4292, 4504, 4505, 4506};
        drive(CMD_RECT, 12, 21, 10, 20, 5, 1'b0);
        capture(20);
        chk("rect_busy", busy_n, 7);
        chk_seq("rect", e);
        chk_data("rect_data", 5);
        drive(CMD_RECT, 10, 20, 12, 21, 5, 1'b0);
        capture(20);
        chk("rect_sw_busy", busy_n, 7);
        chk_seq("rect_sw", e);

        drive(CMD_LINE, 0, 0, 3, 1, 2, 1'b0);
        capture(20);
        chk("line_busy", busy_n, 5);
        e = '{0, 1, 216, 217};
        chk_seq("line", e);
        chk_data("line_data", 2);
        drive(CMD_LINE, 3, 1, 0, 0, 2, 1'b0);
        capture(20);
        e = '{217, 216, 1, 0};
        chk_seq("line_rev", e);
        drive(CMD_LINE, 5, 5, 5, 5, 1, 1'b0);
        capture(20);
        chk("line_pt_busy", busy_n, 2);
        e = '{1075};
        chk_seq("line_pt", e);

        drive(CMD_POINT, 220, 5, 0, 0, 1, 1'b0);
        capture(10);
        chk("clip_pt_busy", busy_n, 2);
        chk("clip_pt_n", wa.size(), 0);

        drive(CMD_RECT, 210, 158, 215, 161, 4, 1'b0);
        capture(50);
        chk("clip_rect_busy", busy_n, 25);
        e = '{34022, 34023, 34024, 34025,
              34236, 34237, 34238, 34239};
        chk_seq("clip_rect", e);

        drive(CMD_RECT, 250, 0, 255, 0, 4, 1'b0);
        capture(50);
        chk("clip_edge_busy", busy_n, 7);
        chk("clip_edge_n", wa.size(), 0);

        drive(raster_command_t'(3'd6), 1, 1, 2, 2, 7, 1'b0);
        capture(10);
        chk("badop_busy", busy_n, 1);
        chk("badop_n", wa.size(), 0);

        drive(CMD_FILL, 0, 0, 0, 0, 3, 1'b1);
        gif.gpu_command = CMD_POINT;
        gif.gpu_x0 = 8'd7;
        gif.gpu_y0 = 8'd1;
        gif.gpu_colour = 3'd4;
        capture(40000);
        chk("fill_busy", busy_n, W * H + 1);
        chk("fill_count", wa.size(), W * H);
        bad = 0;
        foreach (wa[i]) if (wa[i] != i) bad++;
        chk("fill_addr_order", bad, 0);
        chk_data("fill_data", 3);
        @(negedge clk);
        gif.gpu_execute_request = 1'b0;
        chk("held_start", int'(gif.gpu_busy), 1);
        capture(10);
        chk("held_busy", busy_n, 2);
        e = '{221};
        chk_seq("held", e);
        chk_data("held_data", 4);

        drive(CMD_FILL, 0, 0, 0, 0, 2, 1'b0);
        repeat (100) @(negedge clk);
        chk("mid_busy", int'(gif.gpu_busy), 1);
        rst_sync = 1'b1;
        @(negedge clk);
        rst_sync = 1'b0;
        chk("mrst_busy", int'(gif.gpu_busy), 0);
        chk("mrst_wr", int'(gif.fb_write), 0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (gif.fb_write || gif.gpu_busy) bad++;
        end
        chk("mrst_quiet", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
